// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU/branch resolution, latency 1, plus an iterative shift-add multiplier (latency N+1).
// While a multiply is accepted or in flight, stall holds the decode bundle; the held MUL is ignored on the cycle after completion.
module execute_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [4:0]  alu_operation,
  input  logic        dest_register_enable,
  input  logic [4:0]  dest_register_number,
  input  logic [31:0] next_program_counter,
  input  logic [31:0] branch_dest,
  input  logic [31:0] source2_reg_value,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] alu_result,
  output logic        out_dest_register_enable,
  output logic [4:0]  out_dest_register_number,
  output logic [31:0] store_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [4:0] ADDITION       = 5'd0;
  localparam logic [4:0] SUBTRACTION    = 5'd1;
  localparam logic [4:0] MULTIPLICATION = 5'd2;
  localparam logic [4:0] ALU_JALR       = 5'd3;
  localparam logic [4:0] ALU_BEQ        = 5'd4;
  localparam logic [4:0] ALU_BLT        = 5'd5;
  localparam logic [4:0] ALU_BGE        = 5'd6;
  localparam logic [4:0] ALU_BLTU       = 5'd7;
  localparam logic [4:0] ALU_BGEU       = 5'd8;

  localparam int         N         = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [4:0] LAST_ITER = 5'(N - 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state, state_next;

  logic [31:0] mcand, mplier, acc, partial, acc_next;
  logic [31:0] sum, diff, jalr_target;
  logic [4:0]  iter;
  logic        mul_done, accept, start_mul, mul_last, branch_op, taken;

  // mul_done marks the cycle where decode still presents the just-finished MUL.
  assign accept      = in_valid && !redirect_valid && !mul_done && (state == IDLE);
  assign start_mul   = accept && (alu_operation == MULTIPLICATION);
  assign mul_last    = (state == MUL_BUSY) && (iter == LAST_ITER);
  assign stall       = start_mul || (state == MUL_BUSY);

  assign sum         = operand1 + operand2;
  assign diff        = operand1 - operand2;
  assign jalr_target = {sum[31:1], 1'b0};

  always_comb begin
    branch_op = 1'b1;
    taken     = 1'b0;
    case (alu_operation)
      ALU_BEQ:  taken = (operand1 == operand2);
      ALU_BLT:  taken = ($signed(operand1) <  $signed(operand2));
      ALU_BGE:  taken = ($signed(operand1) >= $signed(operand2));
      ALU_BLTU: taken = (operand1 <  operand2);
      ALU_BGEU: taken = (operand1 >= operand2);
      default:  branch_op = 1'b0;
    endcase
  end

  always_comb begin
    partial = '0;
    for (int k = 0; k < MUL_BITS_PER_CYCLE; k++) begin
      if (mplier[k]) partial = partial + (mcand << k);
    end
    acc_next = acc + partial;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_mul) state_next = MUL_BUSY;
      MUL_BUSY: if (mul_last)  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      iter     <= '0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= mul_last;
      if (start_mul) begin
        mcand  <= operand1;
        mplier <= operand2;
        acc    <= '0;
        iter   <= '0;
      end else if (state == MUL_BUSY) begin
        acc    <= acc_next;
        mcand  <= mcand << MUL_BITS_PER_CYCLE;
        mplier <= mplier >> MUL_BITS_PER_CYCLE;
        iter   <= iter + 5'd1;
      end
    end
  end

  // Outputs hold their last values on idle/squashed cycles; only the pulses clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid                <= 1'b0;
      alu_result               <= '0;
      out_dest_register_enable <= 1'b0;
      out_dest_register_number <= '0;
      store_data               <= '0;
      redirect_valid           <= 1'b0;
      redirect_pc              <= '0;
    end else begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      if (mul_last) begin
        out_valid  <= 1'b1;
        alu_result <= acc_next;
      end else if (start_mul) begin
        alu_result               <= '0;
        out_dest_register_enable <= dest_register_enable;
        out_dest_register_number <= dest_register_number;
        store_data               <= source2_reg_value;
      end else if (accept) begin
        out_valid                <= 1'b1;
        out_dest_register_enable <= dest_register_enable && !branch_op;
        out_dest_register_number <= dest_register_number;
        store_data               <= source2_reg_value;
        case (alu_operation)
          SUBTRACTION: alu_result <= diff;
          ALU_JALR: begin
            alu_result     <= next_program_counter;
            redirect_valid <= 1'b1;
            redirect_pc    <= jalr_target;
          end
          default: begin
            if (branch_op) begin
              alu_result     <= '0;
              redirect_valid <= taken;
              redirect_pc    <= branch_dest;
            end else begin
              alu_result <= sum;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, multiply/reset/squash sequences, randomized stream vs reference model.
`timescale 1ns/1ps
module tb_execute_stage;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, MUL = 5'd2, JALR = 5'd3, BEQ = 5'd4,
                         BLT = 5'd5, BGE = 5'd6, BLTU = 5'd7, BGEU = 5'd8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid1 = 1'b0, in_valid4 = 1'b0;
  logic [31:0] operand1 = '0, operand2 = '0, npc = '0, bdest = '0, s2 = '0;
  logic [4:0]  op = '0, rd = '0;
  logic        rd_en = 1'b0;

  logic        stall1, ov1, oden1, rv1, stall4, ov4, oden4, rv4;
  logic [31:0] res1, sd1, rpc1, res4, sd4, rpc4;
  logic [4:0]  odnum1, odnum4;

  execute_stage #(.MUL_BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .operand1(operand1), .operand2(operand2),
    .alu_operation(op), .dest_register_enable(rd_en), .dest_register_number(rd),
    .next_program_counter(npc), .branch_dest(bdest), .source2_reg_value(s2),
    .stall(stall1), .out_valid(ov1), .alu_result(res1), .out_dest_register_enable(oden1),
    .out_dest_register_number(odnum1), .store_data(sd1), .redirect_valid(rv1), .redirect_pc(rpc1));

  execute_stage #(.MUL_BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .operand1(operand1), .operand2(operand2),
    .alu_operation(op), .dest_register_enable(rd_en), .dest_register_number(rd),
    .next_program_counter(npc), .branch_dest(bdest), .source2_reg_value(s2),
    .stall(stall4), .out_valid(ov4), .alu_result(res4), .out_dest_register_enable(oden4),
    .out_dest_register_number(odnum4), .store_data(sd4), .redirect_valid(rv4), .redirect_pc(rpc4));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, npc, bd, s2;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic        exp_en, exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, npc, bd, s2;
    logic        en;
    logic [4:0]  rd;
    bit          gap;
  } instr_t;

  typedef struct {
    logic [31:0] res, s2, rpc;
    logic        en, redir;
    logic [4:0]  rd;
  } exp_t;

  vec_t   vecs[11];
  instr_t prog[$];
  exp_t   expq[$];
  bit     mon_en = 1'b0;
  int     nout = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input instr_t i);
    op = i.op; operand1 = i.a; operand2 = i.b; npc = i.npc;
    bdest = i.bd; s2 = i.s2; rd_en = i.en; rd = i.rd;
  endtask

  // Reference: architectural meaning of one instruction, straight from the ISA rules.
  function automatic exp_t ref_exec(input instr_t i);
    exp_t e;
    logic [63:0] p;
    bit t;
    e.en = i.en; e.rd = i.rd; e.s2 = i.s2; e.redir = 1'b0; e.rpc = '0; e.res = '0;
    t = 1'b0;
    p = {32'b0, i.a} * {32'b0, i.b};
    case (i.op)
      SUB:  e.res = i.a - i.b;
      MUL:  e.res = p[31:0];
      JALR: begin e.res = i.npc; e.redir = 1'b1; e.rpc = (i.a + i.b) & 32'hFFFF_FFFE; end
      BEQ, BLT, BGE, BLTU, BGEU: begin
        if (i.op == BEQ)  t = (i.a == i.b);
        if (i.op == BLT)  t = ($signed(i.a) <  $signed(i.b));
        if (i.op == BGE)  t = ($signed(i.a) >= $signed(i.b));
        if (i.op == BLTU) t = (i.a <  i.b);
        if (i.op == BGEU) t = (i.a >= i.b);
        e.en = 1'b0; e.redir = t; e.rpc = i.bd;
      end
      default: e.res = i.a + i.b;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (ov1) begin
        nout++;
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL stream unexpected out_valid: result 0x%08h, expected no output", res1);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("stream result", res1, e.res);
          check("stream dest_en", oden1, e.en);
          check("stream dest_num", odnum1, e.rd);
          check("stream store_data", sd1, e.s2);
          check("stream redirect_valid", rv1, e.redir);
          if (e.redir) check("stream redirect_pc", rpc1, e.rpc);
        end
      end else if (rv1) begin
        tests++; fails++;
        $display("FAIL stream redirect without out_valid: got 1, expected 0");
      end
    end
  end

  task automatic mul_latency(input int which, input int exp_stall);
    int  cnt, busy_ov;
    bit  st, ov;
    logic [31:0] res;
    logic [4:0]  dn;
    op = MUL; operand1 = 32'hFFFF_FFFE; operand2 = 32'h3; rd = 5'd9; rd_en = 1'b1; s2 = 32'hABCD;
    if (which == 1) in_valid1 = 1'b1; else in_valid4 = 1'b1;
    cnt = 0; busy_ov = 0;
    while (cnt < 100) begin
      @(negedge clk);
      st = (which == 1) ? stall1 : stall4;
      ov = (which == 1) ? ov1 : ov4;
      if (!st) break;
      if (ov) busy_ov++;
      cnt++;
      next_cycle();
    end
    res = (which == 1) ? res1 : res4;
    dn  = (which == 1) ? odnum1 : odnum4;
    check($sformatf("mul%0d stall cycles", which), cnt, exp_stall);
    check($sformatf("mul%0d out_valid during busy", which), busy_ov, 0);
    check($sformatf("mul%0d out_valid", which), (which == 1) ? ov1 : ov4, 1);
    check($sformatf("mul%0d result", which), res, 32'hFFFF_FFFA);
    check($sformatf("mul%0d dest_num", which), dn, 5'd9);
    next_cycle();
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    @(negedge clk);
    check($sformatf("mul%0d single pulse", which), (which == 1) ? ov1 : ov4, 0);
    check($sformatf("mul%0d stall after", which), (which == 1) ? stall1 : stall4, 0);
    next_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, guard, timeouts, nexp;
    bit st, prev_redir;
    instr_t it;
    exp_t e;

    vecs[0]  = '{ADD,   32'h7FFF_FFFF, 32'h1,  32'h4,  32'h0,   32'h11, 1'b1, 5'd5, 32'h8000_0000, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{SUB,   32'h5,         32'h7,  32'h8,  32'h0,   32'h22, 1'b1, 5'd3, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{BLT,   32'hFFFF_FFFF, 32'h1,  32'hC,  32'h100, 32'h33, 1'b1, 5'd2, 32'h0,         1'b0, 1'b1, 32'h100};
    vecs[3]  = '{BLTU,  32'hFFFF_FFFF, 32'h1,  32'hC,  32'h100, 32'h44, 1'b1, 5'd2, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[4]  = '{BEQ,   32'h1234,      32'h1234, 32'h10, 32'h200, 32'h55, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 32'h200};
    vecs[5]  = '{BGE,   32'h8000_0000, 32'h0,  32'h14, 32'h300, 32'h66, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[6]  = '{BGEU,  32'h8000_0000, 32'h0,  32'h14, 32'h300, 32'h77, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h300};
    vecs[7]  = '{JALR,  32'h203,       32'h4,  32'h48, 32'h0,   32'h88, 1'b1, 5'd1, 32'h48,        1'b1, 1'b1, 32'h206};
    vecs[8]  = '{5'd20, 32'hA,         32'h14, 32'h18, 32'h0,   32'h99, 1'b1, 5'd9, 32'h1E,        1'b1, 1'b0, 32'h0};
    vecs[9]  = '{ADD,   32'h1,         32'h2,  32'h1C, 32'h0,   32'hAA, 1'b1, 5'd0, 32'h3,         1'b1, 1'b0, 32'h0};
    vecs[10] = '{BEQ,   32'h1,         32'h2,  32'h20, 32'h400, 32'hBB, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 32'h0};

    #12;
    check("reset out_valid", ov1, 0);
    check("reset alu_result", res1, 0);
    check("reset dest_en", oden1, 0);
    check("reset redirect_valid", rv1, 0);
    check("reset redirect_pc", rpc1, 0);
    check("reset stall", stall1, 0);
    check("reset out_valid x4", ov4, 0);
    @(negedge clk); #2; reset = 1'b1;
    next_cycle();

    for (int i = 0; i < 11; i++) begin
      op = vecs[i].op; operand1 = vecs[i].a; operand2 = vecs[i].b; npc = vecs[i].npc;
      bdest = vecs[i].bd; s2 = vecs[i].s2; rd_en = vecs[i].en; rd = vecs[i].rd;
      in_valid1 = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d stall", i), stall1, 0);
      next_cycle();
      in_valid1 = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), ov1, 1);
      check($sformatf("vec%0d result", i), res1, vecs[i].exp_res);
      check($sformatf("vec%0d dest_en", i), oden1, vecs[i].exp_en);
      check($sformatf("vec%0d dest_num", i), odnum1, vecs[i].rd);
      check($sformatf("vec%0d store_data", i), sd1, vecs[i].s2);
      check($sformatf("vec%0d redirect_valid", i), rv1, vecs[i].exp_redir);
      if (vecs[i].exp_redir) check($sformatf("vec%0d redirect_pc", i), rpc1, vecs[i].exp_rpc);
      next_cycle();
    end

    // JALR followed immediately by a wrong-path instruction
    op = JALR; operand1 = 32'h203; operand2 = 32'h4; npc = 32'h48; rd = 5'd1; rd_en = 1'b1;
    in_valid1 = 1'b1;
    next_cycle();
    op = ADD; operand1 = 32'h1; operand2 = 32'h1; rd = 5'd7;
    @(negedge clk);
    check("squash jalr redirect_valid", rv1, 1);
    check("squash jalr redirect_pc", rpc1, 32'h206);
    check("squash jalr result", res1, 32'h48);
    next_cycle();
    in_valid1 = 1'b0;
    @(negedge clk);
    check("squash out_valid", ov1, 0);
    check("squash redirect pulse", rv1, 0);
    check("squash result held", res1, 32'h48);
    check("squash dest held", odnum1, 5'd1);
    next_cycle();

    mul_latency(1, 33);
    mul_latency(4, 9);

    // Asynchronous reset in the middle of a multiply
    op = MUL; operand1 = 32'h1234_5678; operand2 = 32'h9; rd = 5'd4; rd_en = 1'b1; s2 = 32'h55;
    in_valid1 = 1'b1;
    repeat (10) next_cycle();
    #2;
    reset = 1'b0; in_valid1 = 1'b0;
    #1;
    check("midmul reset out_valid", ov1, 0);
    check("midmul reset dest_en", oden1, 0);
    check("midmul reset dest_num", odnum1, 0);
    check("midmul reset store_data", sd1, 0);
    check("midmul reset result", res1, 0);
    check("midmul reset redirect", rv1, 0);
    check("midmul reset stall", stall1, 0);
    @(negedge clk); #2; reset = 1'b1;
    errs = 0;
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      if (ov1 || stall1) errs++;
    end
    check("midmul aborted no result", errs, 0);
    next_cycle();
    op = ADD; operand1 = 32'd100; operand2 = 32'd23; rd = 5'd6;
    in_valid1 = 1'b1;
    next_cycle();
    in_valid1 = 1'b0;
    @(negedge clk);
    check("post-reset add out_valid", ov1, 1);
    check("post-reset add result", res1, 32'd123);
    next_cycle();

    // Stream: ADD, MUL, ADD then random instructions, upstream honouring stall
    prog.push_back('{ADD, 32'd1, 32'd2, 32'h4, 32'h0, 32'h1, 1'b1, 5'd10, 1'b0});
    prog.push_back('{MUL, 32'd7, 32'd6, 32'h8, 32'h0, 32'h2, 1'b1, 5'd11, 1'b0});
    prog.push_back('{ADD, 32'd5, 32'd5, 32'hC, 32'h0, 32'h3, 1'b1, 5'd12, 1'b0});
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      it.op  = (sel == 9) ? 5'd25 : 5'(sel);
      it.a   = $urandom;
      it.b   = ($urandom_range(0, 3) == 0) ? it.a : (($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 15));
      it.npc = $urandom;
      it.bd  = $urandom;
      it.s2  = $urandom;
      it.en  = 1'($urandom_range(0, 1));
      it.rd  = 5'($urandom_range(0, 31));
      it.gap = ($urandom_range(0, 3) == 0);
      prog.push_back(it);
    end
    prev_redir = 1'b0;
    nexp = 0;
    foreach (prog[k]) begin
      if (prev_redir && !prog[k].gap) begin
        prev_redir = 1'b0;
      end else begin
        e = ref_exec(prog[k]);
        expq.push_back(e);
        nexp++;
        prev_redir = e.redir;
      end
    end

    mon_en = 1'b1;
    timeouts = 0;
    foreach (prog[k]) begin
      if (prog[k].gap) begin
        in_valid1 = 1'b0;
        next_cycle();
      end
      apply(prog[k]);
      in_valid1 = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        st = stall1;
        next_cycle();
        guard++;
      end while (st && guard < 200);
      if (guard >= 200) timeouts++;
    end
    in_valid1 = 1'b0;
    repeat (5) next_cycle();
    mon_en = 1'b0;
    check("stream timeouts", timeouts, 0);
    check("stream leftover expected", expq.size(), 0);
    check("stream output count", nout, nexp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
